stopwatch_datapath: RTL



---
 rtl/stopwatch_pkg.sv | 28 ++
 rtl/bcd_to_7seg.sv | 26 ++
 rtl/stopwatch_datapath.sv | 122 ++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch datapath: active-low 7-segment glyphs,
// display digit positions and seconds-field limits.
package stopwatch_pkg;

    // Active-low segments {dp,g,f,e,d,c,b,a}; dp kept off in every glyph.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        DIG_SEC_ONES = 2'd0,
        DIG_SEC_TENS = 2'd1,
        DIG_MIN_ONES = 2'd2,
        DIG_MIN_TENS = 2'd3
    } digit_e;

    localparam logic [3:0] SEC_MAX_TENS = 4'd5;
    localparam logic [3:0] BCD_MAX_ONES = 4'd9;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder; non-BCD codes go dark.
module bcd_to_7seg
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_datapath.sv
// BCD minutes/seconds counter with a 4-digit multiplexed, blinkable
// 7-segment display driver.
module stopwatch_datapath
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       min_inc,
    input  logic       sec_inc,
    input  logic       blink_en,
    input  logic       blink_phase,
    input  logic       scan_tick,
    output logic [7:0] minutes,
    output logic [7:0] seconds,
    output logic [3:0] an,
    output logic [7:0] seg
);

    localparam logic [7:0] MIN_LAST = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
    localparam logic [7:0] SEC_LAST = {SEC_MAX_TENS, BCD_MAX_ONES};

    // Next BCD value, wrapping to 00 once the field's last value is reached.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        if (v == last)
            return 8'h00;
        else if (v[3:0] == BCD_MAX_ONES)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    logic [7:0] min_p1, sec_p1;
    logic [7:0] min_d, sec_d;
    digit_e     scan_idx, shown_idx, sel;
    logic       lit;
    logic [3:0] nib;
    logic [7:0] glyph;
    logic       blank;
    logic [3:0] an_p1;
    logic [7:0] seg_p1;

    // Carry into minutes only in run mode; adjust modes touch a single field.
    always_comb begin
        min_d = min_p1;
        sec_d = sec_p1;
        if (tick) begin
            if (sec_inc)
                sec_d = bcd_inc(sec_p1, SEC_LAST);
            if (min_inc && (!sec_inc || sec_p1 == SEC_LAST))
                min_d = bcd_inc(min_p1, MIN_LAST);
        end
    end

    // ---- stage p1: counters and scan state ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            min_p1    <= 8'h00;
            sec_p1    <= 8'h00;
            scan_idx  <= DIG_SEC_ONES;
            shown_idx <= DIG_SEC_ONES;
            lit       <= 1'b0;
        end else begin
            min_p1 <= min_d;
            sec_p1 <= sec_d;
            if (scan_tick) begin
                scan_idx  <= digit_e'(scan_idx + 2'd1);
                shown_idx <= scan_idx;
                lit       <= 1'b1;
            end
        end
    end

    // On a scan strobe the incoming digit is decoded from pre-increment counts.
    assign sel = scan_tick ? scan_idx : shown_idx;

    always_comb begin
        nib = sec_p1[3:0];
        case (sel)
            DIG_SEC_ONES: nib = sec_p1[3:0];
            DIG_SEC_TENS: nib = sec_p1[7:4];
            DIG_MIN_ONES: nib = min_p1[3:0];
            DIG_MIN_TENS: nib = min_p1[7:4];
            default:      nib = sec_p1[3:0];
        endcase
    end

    bcd_to_7seg u_dec (
        .bcd (nib),
        .seg (glyph)
    );

    always_comb begin
        blank = 1'b0;
        if (blink_en && blink_phase) begin
            if (min_inc && !sec_inc && (sel == DIG_MIN_ONES || sel == DIG_MIN_TENS))
                blank = 1'b1;
            if (sec_inc && !min_inc && (sel == DIG_SEC_ONES || sel == DIG_SEC_TENS))
                blank = 1'b1;
        end
    end

    // ---- stage p1: registered display outputs ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_p1  <= 4'b1111;
            seg_p1 <= SEG_BLANK;
        end else begin
            if (scan_tick)
                an_p1 <= ~(4'b0001 << scan_idx);
            seg_p1 <= ((lit || scan_tick) && !blank) ? glyph : SEG_BLANK;
        end
    end

    assign minutes = min_p1;
    assign seconds = sec_p1;
    assign an      = an_p1;
    assign seg     = seg_p1;

endmodule
